// File: rtl/rv32_pkg.sv
// Shared RV32I encodings and the LSU state type used by the MEM stage.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_DONE
  } lsu_state_t;

  // Reserved encoding 2'b11 falls back to the ALU result.
  function automatic logic [31:0] wb_mux(input logic [1:0]  sel,
                                         input logic [31:0] alu,
                                         input logic [31:0] pc4,
                                         input logic [31:0] ld);
    case (sel)
      WB_SEL_MEM: return ld;
      WB_SEL_PC4: return pc4;
      default:    return alu;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replication/strobes, misalignment check,
// and load lane select with sign/zero extension.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic        is_store_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic is_byte;
  logic is_half;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // BU/HU codes are only meaningful for loads; on a store they fall back to word.
  always_comb begin
    is_byte = (st_funct3_i == F3_B)  || (!is_store_i && (st_funct3_i == F3_BU));
    is_half = (st_funct3_i == F3_H)  || (!is_store_i && (st_funct3_i == F3_HU));
  end

  always_comb begin
    st_wdata_o = st_data_i;
    st_wstrb_o = '0;
    misalign_o = 1'b0;
    if (is_byte) begin
      st_wdata_o = {4{st_data_i[7:0]}};
      st_wstrb_o = 4'b0001 << st_addr_lo_i;
    end else if (is_half) begin
      st_wdata_o = {2{st_data_i[15:0]}};
      st_wstrb_o = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
      misalign_o = st_addr_lo_i[0];
    end else begin
      st_wstrb_o = '1;
      misalign_o = |st_addr_lo_i;
    end
    if (!is_store_i) st_wstrb_o = '0;
  end

  always_comb begin
    ld_byte = ld_rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
    ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage_lsu.sv
// RV32I MEM stage: non-memory ops pass straight through; loads/stores run a
// req/ack access with timeout, stalling upstream until the DONE cycle.
module memory_stage_lsu
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] instruction_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] pc_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  wb_sel_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        reg_write_out,
  output logic [31:0] rd_sel_mux_out,
  output logic [31:0] instruction_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  lsu_state_t  state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] instr_q, addr_q, pc_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  wb_sel_q;
  logic        we_q, reg_write_q, err_q;

  logic        mem_op, misaligned, accept, last_wait;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;

  lsu_align u_align (
    .st_funct3_i  (instruction_in[14:12]),
    .st_addr_lo_i (alu_result_in[1:0]),
    .st_data_i    (store_data_in),
    .is_store_i   (mem_write_in),
    .st_wdata_o   (st_wdata),
    .st_wstrb_o   (st_wstrb),
    .misalign_o   (misaligned),
    .ld_funct3_i  (instr_q[14:12]),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_rdata_i   (rdata_q),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    mem_op    = valid_in && (mem_read_in || mem_write_in);
    accept    = (state_q == LSU_IDLE) && mem_op && !misaligned;
    last_wait = (state_q == LSU_REQ) && !dmem_ack && (cnt_q == 8'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= LSU_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept) state_d = LSU_REQ;
      LSU_REQ:  if (dmem_ack || last_wait) state_d = LSU_DONE;
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      instr_q     <= '0;
      addr_q      <= '0;
      pc_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wstrb_q     <= '0;
      wb_sel_q    <= '0;
      we_q        <= 1'b0;
      reg_write_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      cnt_q       <= '0;
      instr_q     <= instruction_in;
      addr_q      <= alu_result_in;
      pc_q        <= pc_in;
      wdata_q     <= st_wdata;
      wstrb_q     <= st_wstrb;
      wb_sel_q    <= wb_sel_in;
      we_q        <= mem_write_in;
      reg_write_q <= reg_write_in;
      err_q       <= 1'b0;
    end else if (state_q == LSU_REQ) begin
      if (dmem_ack) begin
        rdata_q <= dmem_rdata;
      end else begin
        cnt_q <= cnt_q + 8'd1;
        if (last_wait) err_q <= 1'b1;
      end
    end
  end

  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;

  // DONE holds a valid follower for one extra cycle so it is first examined in IDLE.
  always_comb begin
    stall_out       = 1'b0;
    dmem_req        = 1'b0;
    reg_write_out   = 1'b0;
    rd_sel_mux_out  = '0;
    instruction_out = NOP_INSTR;
    misalign_out    = 1'b0;
    bus_err_out     = 1'b0;
    if (rst) begin
      case (state_q)
        LSU_IDLE: begin
          if (mem_op) begin
            if (misaligned) begin
              misalign_out    = 1'b1;
              instruction_out = instruction_in;
            end else begin
              stall_out = 1'b1;
            end
          end else if (valid_in) begin
            reg_write_out   = reg_write_in;
            instruction_out = instruction_in;
            rd_sel_mux_out  = wb_mux(wb_sel_in, alu_result_in, pc_in + 32'd4, alu_result_in);
          end
        end
        LSU_REQ: begin
          dmem_req  = 1'b1;
          stall_out = 1'b1;
        end
        LSU_DONE: begin
          stall_out       = valid_in;
          instruction_out = instr_q;
          bus_err_out     = err_q;
          reg_write_out   = reg_write_q && !err_q;
          if (!err_q) rd_sel_mux_out = wb_mux(wb_sel_q, addr_q, pc_q + 32'd4, ld_data);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Randomized bench for memory_stage_lsu with a transaction-level reference model
// and a set of directed cases pinned to hand-computed values.
module tb_memory_stage_lsu;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] instruction_in, alu_result_in, store_data_in, pc_in;
  logic        reg_write_in, mem_read_in, mem_write_in;
  logic [1:0]  wb_sel_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        reg_write_out;
  logic [31:0] rd_sel_mux_out, instruction_out;
  logic        misalign_out, bus_err_out;

  always #5 clk = ~clk;

  memory_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instruction_in(instruction_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .pc_in(pc_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .wb_sel_in(wb_sel_in), .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .reg_write_out(reg_write_out),
    .rd_sel_mux_out(rd_sel_mux_out), .instruction_out(instruction_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one outstanding transaction and where it is in its life.
  int          m_phase = 0;  // 0 free, 1 waiting on memory, 2 result slot
  logic [31:0] t_instr, t_addr, t_pc, t_sd, t_rdata;
  logic        t_store, t_rw, t_err;
  logic [1:0]  t_wb;
  int          t_wait, ack_delay, next_delay = 0;
  int          ack_force = -1;
  bit          rand_rdata = 0;
  bit          last_stall = 0, last_accept = 0;

  int          obs_stall, obs_req, obs_mis, obs_err, obs_rw;
  logic [31:0] obs_rd, obs_addr, obs_wdata;
  logic [3:0]  obs_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3, input logic st);
    if (f3 == 3'd0 || (!st && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (!st && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic st, input logic [31:0] a);
    return (a % op_size(f3, st)) != 0;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    int s = op_size(f3, 1'b1);
    if (s == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (s == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int s = op_size(f3, 1'b1);
    int lane = a % 4;
    if (s == 1) return 4'(1 << lane);
    if (s == 2) return 4'(3 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v = w >> (8 * (a % 4));
    case (f3)
      3'd0: return ((v & 32'hFF) >= 32'h80) ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
      3'd4: return v & 32'hFF;
      3'd1: return ((v & 32'hFFFF) >= 32'h8000) ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
      3'd5: return v & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wb_val(input logic [1:0] wb, input logic [31:0] alu,
                                         input logic [31:0] pc, input logic [31:0] ld);
    if (wb == 2'b01) return ld;
    if (wb == 2'b10) return pc + 32'd4;
    return alu;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [6:0] opc);
    logic [31:0] r = $urandom;
    r[14:12] = f3;
    r[6:0]   = opc;
    return r;
  endfunction

  // Model update with the inputs seen at the edge just taken.
  task automatic tick();
    @(posedge clk);
    if (!rst) m_phase = 0;
    else begin
      case (m_phase)
        0: if (valid_in && (mem_read_in || mem_write_in) &&
               !is_mis(instruction_in[14:12], mem_write_in, alu_result_in)) begin
             t_instr = instruction_in; t_addr = alu_result_in; t_pc = pc_in;
             t_sd = store_data_in; t_store = mem_write_in; t_rw = reg_write_in;
             t_wb = wb_sel_in; t_err = 1'b0; t_wait = 0; ack_delay = next_delay;
             m_phase = 1;
           end
        1: if (dmem_ack) begin
             t_rdata = dmem_rdata; m_phase = 2;
           end else begin
             t_wait++;
             if (t_wait == int'(TO)) begin t_err = 1'b1; m_phase = 2; end
           end
        default: m_phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic finish_cycle();
    logic        e_stall, e_req, e_rw, e_mis, e_err;
    logic [31:0] e_instr, e_rd;
    bit          chk_rd, memop, mis;
    if (ack_force >= 0)   dmem_ack = ack_force[0];
    else if (m_phase == 1) dmem_ack = (t_wait == ack_delay);
    else                   dmem_ack = ($urandom_range(0, 19) == 0);
    if (rand_rdata) dmem_rdata = $urandom;

    memop = valid_in && (mem_read_in || mem_write_in);
    mis   = memop && is_mis(instruction_in[14:12], mem_write_in, alu_result_in);
    e_stall = 0; e_req = 0; e_rw = 0; e_mis = 0; e_err = 0;
    e_instr = NOP; e_rd = '0; chk_rd = 1; last_accept = 0;
    if (rst) begin
      chk_rd = 0;
      case (m_phase)
        0: if (mis) begin
             e_mis = 1; e_instr = instruction_in;
           end else if (memop) begin
             e_stall = 1; last_accept = 1;
           end else if (valid_in) begin
             e_rw = reg_write_in; e_instr = instruction_in; chk_rd = reg_write_in;
             e_rd = wb_val(wb_sel_in, alu_result_in, pc_in, 32'h0);
           end
        1: begin e_req = 1; e_stall = 1; end
        default: begin
          e_stall = valid_in; e_instr = t_instr; e_err = t_err;
          e_rw = t_rw && !t_err; chk_rd = e_rw;
          e_rd = wb_val(t_wb, t_addr, t_pc, exp_load(t_instr[14:12], t_addr, t_rdata));
        end
      endcase
    end

    @(negedge clk);
    chk("stall_out", stall_out, e_stall);
    chk("dmem_req", dmem_req, e_req);
    chk("reg_write_out", reg_write_out, e_rw);
    chk("instruction_out", instruction_out, e_instr);
    chk("misalign_out", misalign_out, e_mis);
    chk("bus_err_out", bus_err_out, e_err);
    if (chk_rd) chk("rd_sel_mux_out", rd_sel_mux_out, e_rd);
    if (e_req) begin
      chk("dmem_addr", dmem_addr, t_addr & 32'hFFFF_FFFC);
      chk("dmem_we", dmem_we, t_store);
      chk("dmem_wstrb", dmem_wstrb, t_store ? exp_wstrb(t_instr[14:12], t_addr) : 4'h0);
      if (t_store) chk("dmem_wdata", dmem_wdata, exp_wdata(t_instr[14:12], t_sd));
    end
    last_stall = e_stall;

    obs_stall += stall_out;
    obs_req   += dmem_req;
    obs_mis   += misalign_out;
    obs_err   += bus_err_out;
    obs_rw    += reg_write_out;
    if (reg_write_out) obs_rd = rd_sel_mux_out;
    if (dmem_req) begin obs_addr = dmem_addr; obs_wdata = dmem_wdata; obs_wstrb = dmem_wstrb; end
  endtask

  task automatic clear_obs();
    obs_stall = 0; obs_req = 0; obs_mis = 0; obs_err = 0; obs_rw = 0;
    obs_rd = 32'hDEAD_BEEF; obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
  endtask

  task automatic drive_op(input logic v, input logic [31:0] instr, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [31:0] pc, input logic rw,
                          input logic mr, input logic mw, input logic [1:0] wb);
    valid_in = v; instruction_in = instr; alu_result_in = alu; store_data_in = sd;
    pc_in = pc; reg_write_in = rw; mem_read_in = mr; mem_write_in = mw; wb_sel_in = wb;
  endtask

  task automatic drive_bubble();
    drive_op(1'b0, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic run_op(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [31:0] pc, input logic rw, input logic mr, input logic mw,
                        input logic [1:0] wb, input int delay, input int ncyc);
    clear_obs();
    next_delay = delay;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (i == 0) drive_op(1'b1, instr, alu, sd, pc, rw, mr, mw, wb);
      else        drive_bubble();
      finish_cycle();
    end
  endtask

  task automatic gen_random();
    int k = $urandom_range(0, 99);
    drive_op(1'b1, mk_instr(3'($urandom_range(0, 7)), 7'h33), $urandom, $urandom, $urandom,
             1'b1, 1'b0, 1'b0, 2'b00);
    if (k < 15) begin
      valid_in = 1'b0; reg_write_in = 1'($urandom); mem_read_in = 1'($urandom);
    end else if (k < 35) begin
      reg_write_in = 1'($urandom); wb_sel_in = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
    end else if (k < 45) begin
      wb_sel_in = 2'b10;
      if ($urandom_range(0, 3) == 0) pc_in = 32'hFFFF_FFFC;
    end else if (k < 72) begin
      mem_read_in = 1'b1; wb_sel_in = 2'b01;
    end else begin
      mem_write_in = 1'b1; reg_write_in = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    drive_bubble();
    clear_obs();

    // Reset state
    for (int i = 0; i < 2; i++) begin tick(); finish_cycle(); end
    chk("reset_instr_nop", instruction_out, 32'h0000_0013);
    chk("reset_stall", stall_out, 1'b0);
    tick(); rst = 1'b1; finish_cycle();

    // SB 0xA5 at 0x1003
    run_op(mk_instr(3'd0, 7'h23), 32'h1003, 32'h0000_00A5, 32'h100, 1'b0, 1'b0, 1'b1, 2'b00, 0, 3);
    chk("sb_addr", obs_addr, 32'h1000);
    chk("sb_wstrb", obs_wstrb, 4'b1000);
    chk("sb_wdata", obs_wdata, 32'hA5A5_A5A5);

    // SH at 0x1002
    run_op(mk_instr(3'd1, 7'h23), 32'h1002, 32'h1234_BEEF, 32'h104, 1'b0, 1'b0, 1'b1, 2'b00, 1, 4);
    chk("sh_wstrb", obs_wstrb, 4'b1100);
    chk("sh_wdata", obs_wdata, 32'hBEEF_BEEF);

    // LB / LBU at 0x2001, ack on third REQ cycle
    dmem_rdata = 32'h0000_8000;
    run_op(mk_instr(3'd0, 7'h03), 32'h2001, 32'h0, 32'h108, 1'b1, 1'b1, 1'b0, 2'b01, 2, 5);
    chk("lb_stall_cycles", obs_stall, 4);
    chk("lb_req_cycles", obs_req, 3);
    chk("lb_rd", obs_rd, 32'hFFFF_FF80);
    run_op(mk_instr(3'd4, 7'h03), 32'h2001, 32'h0, 32'h10C, 1'b1, 1'b1, 1'b0, 2'b01, 2, 5);
    chk("lbu_rd", obs_rd, 32'h0000_0080);

    // LW misaligned at 0x2002
    run_op(mk_instr(3'd2, 7'h03), 32'h2002, 32'h0, 32'h110, 1'b1, 1'b1, 1'b0, 2'b01, 0, 2);
    chk("lw_mis_pulse", obs_mis, 1);
    chk("lw_mis_req", obs_req, 0);
    chk("lw_mis_stall", obs_stall, 0);
    chk("lw_mis_rw", obs_rw, 0);

    // Timeout with no ack
    run_op(mk_instr(3'd2, 7'h03), 32'h2004, 32'h0, 32'h114, 1'b1, 1'b1, 1'b0, 2'b01, 99, 6);
    chk("to_req_cycles", obs_req, 4);
    chk("to_bus_err", obs_err, 1);
    chk("to_rw", obs_rw, 0);

    // JAL at the top of the address space
    run_op(mk_instr(3'd0, 7'h6F), 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 2'b10, 0, 1);
    chk("jal_rd", obs_rd, 32'h0);
    chk("jal_rw", obs_rw, 1);
    chk("jal_stall", obs_stall, 0);

    // Reset in the middle of a request, with a late ack
    run_op(mk_instr(3'd2, 7'h03), 32'h3000, 32'h0, 32'h118, 1'b1, 1'b1, 1'b0, 2'b01, 99, 2);
    ack_force = 1;
    for (int i = 0; i < 2; i++) begin tick(); rst = 1'b0; drive_bubble(); finish_cycle(); end
    tick(); rst = 1'b1; drive_bubble(); finish_cycle();
    chk("rst_mid_req", dmem_req, 1'b0);
    chk("rst_mid_stall", stall_out, 1'b0);
    chk("rst_mid_instr", instruction_out, 32'h0000_0013);
    ack_force = -1;

    // Randomized traffic
    rand_rdata = 1;
    begin
      int rst_left = 0;
      for (int c = 0; c < 3000; c++) begin
        bit hold = last_stall && !last_accept;
        tick();
        if (rst_left > 0) rst_left--;
        else if ($urandom_range(0, 99) == 0) rst_left = $urandom_range(1, 2);
        rst = (rst_left == 0);
        if (!hold || !rst) gen_random();
        finish_cycle();
        next_delay = ($urandom_range(0, 6) == 0) ? 99 : $urandom_range(0, 3);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
